uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the default abort limit for a byte that never completes.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans upward from the requester after
// the last one served and reports the first active request.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_sig,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               valid
);

  logic [IDX_W-1:0] cand_s;

  // first requester found at or after last+1 (modulo NUM_REQ) wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand_s = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IDX_W'((int'(last) + i) % NUM_REQ);
      winner = (!valid && req_sig[cand_s]) ? cand_s : winner;
      valid  = valid | req_sig[cand_s];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources: round-robin grant,
// one byte per grant, per-byte abort timer and a one-cycle gap between bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter int IDX_W       = $clog2(NUM_REQ),
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic                   CLK,
  input  logic                   Rstn,
  input  logic [NUM_REQ-1:0]     Req_Sig,
  input  logic [8*NUM_REQ-1:0]   Req_Data,
  output logic [NUM_REQ-1:0]     Ack_Sig,
  output logic                   Err_Sig,
  output logic                   TX_En_Sig,
  output logic [7:0]             TX_Data,
  input  logic                   TX_Done_Sig,
  output logic                   Busy_Sig,
  output logic [IDX_W-1:0]       Grant_Idx
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  state_t               state_r,   state_nx_s;
  logic                 tx_en_r,   tx_en_nx_s;
  logic [7:0]           tx_data_r, tx_data_nx_s;
  logic [IDX_W-1:0]     grant_r,   grant_nx_s;
  logic [IDX_W-1:0]     last_r,    last_nx_s;
  logic [CNT_W-1:0]     cnt_r,     cnt_nx_s;
  logic [NUM_REQ-1:0]   ack_r,     ack_nx_s;
  logic                 err_r,     err_nx_s;
  logic                 busy_r;
  logic [IDX_W-1:0]     win_s;
  logic                 win_valid_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_sig (Req_Sig),
    .last    (last_r),
    .winner  (win_s),
    .valid   (win_valid_s)
  );

  // next-state and next-output decode; Ack/Err default low so they only pulse
  always_comb begin
    state_nx_s   = state_r;
    tx_en_nx_s   = tx_en_r;
    tx_data_nx_s = tx_data_r;
    grant_nx_s   = grant_r;
    last_nx_s    = last_r;
    cnt_nx_s     = cnt_r;
    ack_nx_s     = '0;
    err_nx_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_valid_s) begin
          state_nx_s   = ST_SEND;
          tx_en_nx_s   = 1'b1;
          tx_data_nx_s = Req_Data[{win_s, 3'b000} +: 8];
          grant_nx_s   = win_s;
          cnt_nx_s     = '0;
        end else begin
          tx_en_nx_s   = 1'b0;
        end
      end
      ST_SEND: begin
        // completion wins over a coincident timeout
        if (TX_Done_Sig) begin
          state_nx_s        = ST_GAP;
          tx_en_nx_s        = 1'b0;
          ack_nx_s[grant_r] = 1'b1;
          last_nx_s         = grant_r;
        end else if (cnt_r == CNT_LAST) begin
          state_nx_s = ST_GAP;
          tx_en_nx_s = 1'b0;
          err_nx_s   = 1'b1;
          last_nx_s  = grant_r;
        end else begin
          cnt_nx_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_nx_s = ST_IDLE;
        tx_en_nx_s = 1'b0;
      end
      default: begin
        state_nx_s = ST_IDLE;
        tx_en_nx_s = 1'b0;
      end
    endcase
  end

  // state and output registers; reset leaves requester 0 next in line
  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      state_r   <= ST_IDLE;
      tx_en_r   <= 1'b0;
      tx_data_r <= 8'h00;
      grant_r   <= '0;
      last_r    <= LAST_RST;
      cnt_r     <= '0;
      ack_r     <= '0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      tx_en_r   <= tx_en_nx_s;
      tx_data_r <= tx_data_nx_s;
      grant_r   <= grant_nx_s;
      last_r    <= last_nx_s;
      cnt_r     <= cnt_nx_s;
      ack_r     <= ack_nx_s;
      err_r     <= err_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
    end
  end

  assign TX_En_Sig = tx_en_r;
  assign TX_Data   = tx_data_r;
  assign Grant_Idx = grant_r;
  assign Ack_Sig   = ack_r;
  assign Err_Sig   = err_r;
  assign Busy_Sig  = busy_r;

endmodule
